// File: rtl/lfsr_rng.sv
// Galois LFSR random-number generator: seed load, idle stirring, and a
// req/valid/ready word interface with rejection sampling against a limit.
`timescale 1ns/1ps

module lfsr_rng #(
    parameter int                WIDTH      = 16,
    parameter logic [WIDTH-1:0]  TAPS       = 16'hB400,
    parameter int                OUT_W      = 8,
    parameter logic [WIDTH-1:0]  RESET_SEED = 16'h0001
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [WIDTH-1:0]  seed,
    input  logic              load,
    input  logic              stir,
    input  logic              req,
    input  logic [OUT_W-1:0]  limit,
    input  logic              rnd_ready,
    output logic              out,
    output logic              busy,
    output logic [OUT_W-1:0]  rnd,
    output logic              rnd_valid
);

    localparam int CNT_W = (OUT_W < 2) ? 1 : $clog2(OUT_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        VALID = 2'd2
    } fsm_t;

    fsm_t             fsm_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_next;
    logic             fb;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] word;
    logic [OUT_W-1:0] lim_q;
    logic [OUT_W-1:0] rnd_q;
    logic             rnd_valid_q;
    logic [CNT_W-1:0] cnt_q;

    // Shifting acc left and OR-ing in the bit also covers OUT_W == 1.
    always_comb begin
        fb        = lfsr_q[0];
        lfsr_next = (lfsr_q >> 1) ^ (fb ? TAPS : '0);
        word      = (acc_q << 1) | OUT_W'(fb);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            fsm_q       <= IDLE;
            lfsr_q      <= RESET_SEED;
            acc_q       <= '0;
            cnt_q       <= '0;
            lim_q       <= '0;
            rnd_q       <= '0;
            rnd_valid_q <= 1'b0;
        end else if (load) begin
            // A zero seed would lock the register up, so it is replaced by 1.
            lfsr_q      <= (seed == '0) ? WIDTH'(1) : seed;
            fsm_q       <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            rnd_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (req) begin
                        lim_q <= limit;
                        cnt_q <= '0;
                        acc_q <= '0;
                        fsm_q <= SHIFT;
                    end else if (stir) begin
                        lfsr_q <= lfsr_next;
                    end
                end
                SHIFT: begin
                    lfsr_q <= lfsr_next;
                    if (cnt_q == LAST) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                        if (word <= lim_q) begin
                            rnd_q       <= word;
                            rnd_valid_q <= 1'b1;
                            fsm_q       <= VALID;
                        end
                    end else begin
                        acc_q <= word;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                VALID: begin
                    // The handoff edge may also accept the next request.
                    if (rnd_ready) begin
                        rnd_valid_q <= 1'b0;
                        if (req) begin
                            lim_q <= limit;
                            cnt_q <= '0;
                            acc_q <= '0;
                            fsm_q <= SHIFT;
                        end else begin
                            fsm_q <= IDLE;
                        end
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign out       = lfsr_q[0];
    assign busy      = (fsm_q != IDLE);
    assign rnd       = rnd_q;
    assign rnd_valid = rnd_valid_q;

endmodule

// File: doc/lfsr_rng.md
# lfsr_rng

Parametrised Galois LFSR random-number generator with seed load, idle stirring, and a request/valid/ready word interface. Produces OUT_W-bit random words, optionally bounded by rejection sampling against a per-request limit. Feeds spawn/lane selection in the game logic while keeping the single-bit serial `out` of the 8-bit generator.

## Interface
- WIDTH, 16: LFSR state width, ≥ 2.
- TAPS, 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1); must be maximal-length for WIDTH.
- OUT_W, 8: random word width, 1 ≤ OUT_W ≤ WIDTH.
- RESET_SEED, 16'h0001: state after reset; must be nonzero.
- clk  in  1  single clock, all state on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- seed  in  WIDTH  value loaded when `load`=1.
- load  in  1  synchronous seed load, highest priority after reset.
- stir  in  1  step LFSR every cycle while IDLE.
- req  in  1  request a new word.
- limit  in  OUT_W  inclusive upper bound, sampled when req is accepted.
- rnd_ready  in  1  consumer accepts `rnd`.
- out  out  1  serial bit = state[0], continuous.
- busy  out  1  FSM not IDLE.
- rnd  out  OUT_W  random word, valid when rnd_valid=1.
- rnd_valid  out  1  word available.

## Operation
- LFSR step: b = state[0]; state ← (state >> 1) ^ (b ? TAPS : 0). Shift-in to word: acc ← {acc[OUT_W-2:0], b} (MSB-first; for OUT_W=1 acc ← b).
- Load: state ← seed, or 1 if seed==0 (lockup prevention). Aborts any request: FSM → IDLE, rnd_valid ← 0, acc/counter cleared; rnd retains last value. Same-edge req/stir ignored.
- FSM states IDLE, SHIFT, VALID.
- IDLE: req=1 → capture limit into lim_q, cnt ← 0, → SHIFT (no LFSR step on this edge). Else if stir=1 → one LFSR step. Else hold.
- SHIFT: one LFSR step and one acc shift per edge, cnt++. On the OUT_W-th step edge evaluate the completed word w = {acc[OUT_W-2:0], b}: if w ≤ lim_q → rnd ← w, rnd_valid ← 1, → VALID; else cnt ← 0, stay SHIFT (reject, new attempt). req, stir, limit ignored.
- VALID: LFSR frozen. rnd_ready=1 → rnd_valid ← 0; if req=1 same edge → capture limit, → SHIFT (back-to-back), else → IDLE. rnd_ready=0 → hold rnd, rnd_valid.
- limit = all ones never rejects. limit=0 is legal (waits for an all-zero word).
- busy = (FSM ≠ IDLE), combinational from state.

## Timing
- Reset (clr=0, async): state ← RESET_SEED, FSM IDLE, acc 0, cnt 0, rnd 0, rnd_valid 0, busy 0, out = RESET_SEED[0]. Release synchronous to design usage; first active edge after release may accept req.
- Latency: req accepted at edge E; rnd_valid visible after edge E+OUT_W per attempt; each rejection adds OUT_W edges.
- Throughput without rejection: one word per OUT_W+1 cycles with req held high and rnd_ready=1 (handoff edge doubles as accept edge).
- out changes only on edges where the LFSR steps or loads.
- Reset asserted mid-SHIFT or in VALID: immediate return to reset values; no partial word emitted.

## Test plan
- Reset with RESET_SEED=1 -> out=1, busy=0, rnd_valid=0, rnd=0 while clr=0 and after release.
- load seed=0x0001, req with limit=0xFF, rnd_ready=0 -> busy=1 from next cycle, rnd_valid rises 8 edges after accept, rnd=0x80, held stable until rnd_ready; LFSR state 0x0168 afterward.
- Continue with req, limit=0xFF -> rnd=0x16, state 0x7C41; with limit=0x7F from fresh seed 1 -> 0x80 rejected, rnd=0x16 after 16 step edges.
- load seed=0 -> state 0x0001 (out=1); load asserted mid-SHIFT -> rnd_valid stays 0, busy=0 next cycle, state = new seed.
- stir=1 in IDLE from seed 1 for 4 cycles -> states 0xB400, 0x5A00, 0x2D00, 0x1680; stir ignored during SHIFT/VALID.
- VALID with rnd_ready=1 and req=1 same edge -> rnd_valid drops, busy stays 1, next word after 8 edges; free-run 65535 steps from seed 1 returns to 0x0001, never 0.
